// File: rtl/rv_timer_irq_pkg.sv
// Shared register map, bit positions and types for the uRV timer-interrupt compare unit.
// The periodic feature is selected by URV_TIMER_PERIODIC_EN in rv_timer_irq.
package rv_timer_irq_pkg;

    localparam int unsigned TIME_W = 40;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CMP_LO = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CMP_HI = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd4;

    localparam int unsigned CTRL_EN_BIT        = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT    = 1;
    localparam int unsigned CTRL_PERIODIC_BIT  = 2;
    localparam int unsigned STATUS_PENDING_BIT = 0;
    localparam int unsigned STATUS_OVERRUN_BIT = 1;

    localparam logic [TIME_W-1:0] CMP_RESET = 40'hFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    // Field order matches the CTRL / STATUS bit layout so the structs read back directly.
    typedef struct packed {
        logic periodic;
        logic irq_en;
        logic en;
    } ctrl_t;

    typedef struct packed {
        logic overrun;
        logic pending;
    } status_t;

endpackage

// File: rtl/rv_timer_irq_cmp.sv
// 40-bit compare register with split-word writes, periodic reload adder and >= comparator.
module rv_timer_irq_cmp
    import rv_timer_irq_pkg::*;
#(
    parameter int unsigned g_period_width = 24
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [TIME_W-1:0]         time_i,
    input  logic                      wr_lo,
    input  logic                      wr_hi,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      reload,
    input  logic [g_period_width-1:0] period,
    output logic [TIME_W-1:0]         cmp,
    output logic                      ge_c
);

    logic [TIME_W-1:0] cmp_base;
    logic [TIME_W-1:0] cmp_d;

    // Software writes take priority over the reload for the word they touch.
    always_comb begin
        cmp_base = reload ? (cmp + TIME_W'(period)) : cmp;
        cmp_d    = cmp_base;
        if (wr_lo) begin
            cmp_d[DATA_W-1:0] = wdata;
        end
        if (wr_hi) begin
            cmp_d[TIME_W-1:DATA_W] = wdata[TIME_W-DATA_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp <= CMP_RESET;
        end else begin
            cmp <= cmp_d;
        end
    end

    assign ge_c = (time_i >= cmp);

endmodule

// File: rtl/rv_timer_irq.sv
// uRV timer-interrupt unit: register file, IDLE/HOLD/ARMED control FSM and level interrupt.
// Define URV_TIMER_PERIODIC_EN to implement PERIOD, CTRL.PERIODIC and auto-reload.
module rv_timer_irq
    import rv_timer_irq_pkg::*;
#(
    parameter int unsigned g_period_width = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic [TIME_W-1:0] time_i,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              irq_o
);

    state_e                    state_q, state_d;
    ctrl_t                     ctrl_q, ctrl_d;
    status_t                   status_q, status_d;
    logic                      gate_q, gate_d;
    logic [g_period_width-1:0] period_q, period_d;
    logic [DATA_W-1:0]         rdata_d;
    logic                      irq_d;

    logic [TIME_W-1:0] cmp;
    logic              ge_c;
    logic              hit_c;
    logic              reload_c;
    logic              wr_ctrl, wr_status, wr_lo, wr_hi;

    assign wr_ctrl   = wr_i && (addr_i == ADDR_CTRL);
    assign wr_status = wr_i && (addr_i == ADDR_STATUS);
    assign wr_lo     = wr_i && (addr_i == ADDR_CMP_LO);
    assign wr_hi     = wr_i && (addr_i == ADDR_CMP_HI);

    // The gate holds off repeat hits of a zero-period reload until the next tick.
    assign hit_c    = (state_q == ST_ARMED) && !gate_q && ge_c;
    assign reload_c = hit_c && ctrl_q.periodic;

    rv_timer_irq_cmp #(
        .g_period_width(g_period_width)
    ) u_cmp (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .time_i (time_i),
        .wr_lo  (wr_lo),
        .wr_hi  (wr_hi),
        .wdata  (wdata_i),
        .reload (reload_c),
        .period (period_q),
        .cmp    (cmp),
        .ge_c   (ge_c)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        status_d = status_q;
        gate_d   = gate_q;
        period_d = period_q;
        rdata_d  = rdata_o;

        case (state_q)
            ST_HOLD: begin
                if (wr_hi) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (hit_c && !ctrl_q.periodic) begin
                    state_d = ST_IDLE;
                end else if (wr_lo) begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (hit_c && !ctrl_q.periodic) begin
            ctrl_d.en = 1'b0;
        end

        // A CTRL write overrides a same-cycle one-shot disarm; HOLD survives a re-enable.
        if (wr_ctrl) begin
            ctrl_d.en     = wdata_i[CTRL_EN_BIT];
            ctrl_d.irq_en = wdata_i[CTRL_IRQ_EN_BIT];
            if (!wdata_i[CTRL_EN_BIT]) begin
                state_d = ST_IDLE;
            end else if (state_q != ST_HOLD) begin
                state_d = ST_ARMED;
            end
        end

`ifdef URV_TIMER_PERIODIC_EN
        if (wr_ctrl) begin
            ctrl_d.periodic = wdata_i[CTRL_PERIODIC_BIT];
        end
        if (wr_i && (addr_i == ADDR_PERIOD)) begin
            period_d = wdata_i[g_period_width-1:0];
        end
`endif

        status_d.pending = hit_c ||
                           (status_q.pending && !(wr_status && wdata_i[STATUS_PENDING_BIT]));
        status_d.overrun = (hit_c && status_q.pending) ||
                           (status_q.overrun && !(wr_status && wdata_i[STATUS_OVERRUN_BIT]));

        if ((state_d != ST_ARMED) || tick_i) begin
            gate_d = 1'b0;
        end else if (reload_c && (period_q == '0)) begin
            gate_d = 1'b1;
        end

        if (rd_i) begin
            case (addr_i)
                ADDR_CTRL:   rdata_d = DATA_W'(ctrl_q);
                ADDR_STATUS: rdata_d = DATA_W'(status_q);
                ADDR_CMP_LO: rdata_d = cmp[DATA_W-1:0];
                ADDR_CMP_HI: rdata_d = DATA_W'(cmp[TIME_W-1:DATA_W]);
                ADDR_PERIOD: rdata_d = DATA_W'(period_q);
                default:     rdata_d = '0;
            endcase
        end

        irq_d = status_d.pending && ctrl_d.irq_en;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            status_q <= '0;
            gate_q   <= 1'b0;
            period_q <= '0;
            rdata_o  <= '0;
            irq_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            gate_q   <= gate_d;
            period_q <= period_d;
            rdata_o  <= rdata_d;
            irq_o    <= irq_d;
        end
    end

endmodule

// File: tb/tb_rv_timer_irq.sv
// Self-checking bench for rv_timer_irq: directed table, corner sequences and random run vs a model.
module tb_rv_timer_irq;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [39:0] tm;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv_timer_irq #(
        .g_period_width(24)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .tick_i  (tick),
        .time_i  (tm),
        .wr_i    (wr),
        .rd_i    (rd),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .irq_o   (irq)
    );

    // Behavioural model state: what software would observe after each clock edge.
    bit          m_en, m_irq_en, m_per, m_hold, m_gate, m_pend, m_ovr, m_irq;
    logic [39:0] m_cmp;
    logic [23:0] m_period;
    logic [31:0] m_rdata;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {29'b0, m_per, m_irq_en, m_en};
            3'd1:    return {30'b0, m_ovr, m_pend};
            3'd2:    return m_cmp[31:0];
            3'd3:    return {24'b0, m_cmp[39:32]};
            3'd4:    return {8'b0, m_period};
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit w, input bit rdd, input logic [2:0] a,
                              input logic [31:0] d, input bit tk, input logic [39:0] t);
        bit          hit;
        bit          pend_old;
        logic [39:0] nc;
        if (r) begin
            m_en = 0; m_irq_en = 0; m_per = 0; m_hold = 0; m_gate = 0;
            m_pend = 0; m_ovr = 0; m_irq = 0;
            m_cmp = 40'hFF_FFFF_FFFF; m_period = 0; m_rdata = 0;
            return;
        end
        hit = m_en && !m_hold && !m_gate && (t >= m_cmp);
        if (rdd) m_rdata = model_read(a);
        pend_old = m_pend;
        m_pend = hit || (m_pend && !(w && a == 3'd1 && d[0]));
        m_ovr  = (hit && pend_old) || (m_ovr && !(w && a == 3'd1 && d[1]));
        nc = m_cmp;
        if (hit && m_per) begin
            nc = m_cmp + {16'b0, m_period};
            if (m_period == 0) m_gate = 1;
        end else if (hit) begin
            m_en = 0;
        end
        if (w) begin
            case (a)
                3'd0: begin
                    if (!d[0] || !m_en) m_hold = 0;
                    m_en     = d[0];
                    m_irq_en = d[1];
`ifdef URV_TIMER_PERIODIC_EN
                    m_per    = d[2];
`endif
                end
                3'd2: begin
                    nc[31:0] = d;
                    if (m_en) m_hold = 1;
                end
                3'd3: begin
                    nc[39:32] = d[7:0];
                    m_hold = 0;
                end
                3'd4: begin
`ifdef URV_TIMER_PERIODIC_EN
                    m_period = d[23:0];
`endif
                end
                default: ;
            endcase
        end
        m_cmp = nc;
        if (tk || !m_en || m_hold) m_gate = 0;
        m_irq = m_pend && m_irq_en;
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge and compare.
    task automatic step(input bit r, input bit w, input bit rdd, input logic [2:0] a,
                        input logic [31:0] d, input bit tk, input logic [39:0] t);
        rst = r; wr = w; rd = rdd; addr = a; wdata = d; tick = tk; tm = t;
        model_step(r, w, rdd, a, d, tk, t);
        @(posedge clk);
        #1;
        check("model irq_o", {39'b0, irq}, {39'b0, m_irq});
        check("model rdata_o", {8'b0, rdata}, {8'b0, m_rdata});
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        bit          rdd;
        logic [2:0]  a;
        logic [31:0] d;
        logic [39:0] t;
        bit          exp_irq;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];
    int   hits;
    int   hsum;
    logic [39:0] tr;

    initial begin
        rst = 1; tick = 0; tm = 0; wr = 0; rd = 0; addr = 0; wdata = 0;

        // One-shot compare
        vecs[0]  = '{1, 0, 0, 3'd0, 32'd0,   40'd0,   0, 32'd0};
        vecs[1]  = '{0, 1, 0, 3'd2, 32'd100, 40'd0,   0, 32'd0};
        vecs[2]  = '{0, 1, 0, 3'd3, 32'd0,   40'd0,   0, 32'd0};
        vecs[3]  = '{0, 1, 0, 3'd0, 32'd3,   40'd0,   0, 32'd0};
        vecs[4]  = '{0, 0, 0, 3'd0, 32'd0,   40'd99,  0, 32'd0};
        vecs[5]  = '{0, 0, 0, 3'd0, 32'd0,   40'd100, 1, 32'd0};
        vecs[6]  = '{0, 0, 1, 3'd0, 32'd0,   40'd101, 1, 32'd2};
        vecs[7]  = '{0, 0, 1, 3'd1, 32'd0,   40'd102, 1, 32'd1};
        vecs[8]  = '{0, 1, 0, 3'd1, 32'd1,   40'd103, 0, 32'd1};
        vecs[9]  = '{0, 0, 1, 3'd1, 32'd0,   40'd104, 0, 32'd0};
        vecs[10] = '{0, 0, 1, 3'd6, 32'd0,   40'd200, 0, 32'd0};
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].r, vecs[i].w, vecs[i].rdd, vecs[i].a, vecs[i].d, 0, vecs[i].t);
            check($sformatf("vec%0d irq_o", i), {39'b0, irq}, {39'b0, vecs[i].exp_irq});
            check($sformatf("vec%0d rdata_o", i), {8'b0, rdata}, {8'b0, vecs[i].exp_rdata});
        end

        // Torn update: old cmp 0x0_9000_0000, target 0x1_0000_0010, time 0x50
        do_reset();
        step(0, 1, 0, 3'd3, 32'h0,         0, 40'h50);
        step(0, 1, 0, 3'd2, 32'h9000_0000, 0, 40'h50);
        step(0, 1, 0, 3'd0, 32'd3,         0, 40'h50);
        step(0, 0, 0, 3'd0, 32'd0,         0, 40'h50);
        step(0, 1, 0, 3'd2, 32'h10,        0, 40'h50);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 3'd0, 32'd0, 1, 40'h50);
            check("torn hold irq_o", {39'b0, irq}, 40'd0);
        end
        step(0, 1, 0, 3'd3, 32'd1, 0, 40'h50);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd0, 32'd0, 0, 40'h51);
        check("torn after irq_o", {39'b0, irq}, 40'd0);
        step(0, 0, 1, 3'd1, 32'd0, 0, 40'h51);
        check("torn status", {8'b0, rdata}, 40'd0);

        // Set wins over W1C, then overrun on a second hit
        do_reset();
        step(0, 1, 0, 3'd2, 32'd50, 0, 40'd0);
        step(0, 1, 0, 3'd3, 32'd0,  0, 40'd0);
        step(0, 1, 0, 3'd0, 32'd3,  0, 40'd49);
        step(0, 0, 0, 3'd0, 32'd0,  0, 40'd49);
        step(0, 1, 0, 3'd1, 32'd1,  0, 40'd50);
        check("setwins irq_o", {39'b0, irq}, 40'd1);
        step(0, 0, 1, 3'd1, 32'd0,  0, 40'd50);
        check("setwins status", {8'b0, rdata}, 40'd1);
        step(0, 1, 0, 3'd0, 32'd3,  0, 40'd50);
        step(0, 0, 0, 3'd0, 32'd0,  0, 40'd50);
        step(0, 0, 1, 3'd1, 32'd0,  0, 40'd50);
        check("overrun status", {8'b0, rdata}, 40'd3);

        // Masking and reset mid-operation
        step(0, 1, 0, 3'd0, 32'd0, 0, 40'd50);
        check("masked irq_o", {39'b0, irq}, 40'd0);
        step(0, 1, 0, 3'd0, 32'd2, 0, 40'd50);
        check("unmasked irq_o", {39'b0, irq}, 40'd1);
        step(1, 0, 0, 3'd0, 32'd0, 0, 40'd50);
        check("reset irq_o", {39'b0, irq}, 40'd0);
        step(0, 0, 1, 3'd2, 32'd0, 0, 40'd50);
        check("reset cmp_lo", {8'b0, rdata}, 40'hFFFF_FFFF);
        step(0, 0, 1, 3'd3, 32'd0, 0, 40'd50);
        check("reset cmp_hi", {8'b0, rdata}, 40'hFF);

`ifdef URV_TIMER_PERIODIC_EN
        // Periodic: cmp=10, PERIOD=5, time 0..30; STATUS cleared every cycle
        do_reset();
        step(0, 1, 0, 3'd2, 32'd10, 0, 0);
        step(0, 1, 0, 3'd3, 32'd0,  0, 0);
        step(0, 1, 0, 3'd4, 32'd5,  0, 0);
        step(0, 1, 0, 3'd0, 32'd7,  0, 0);
        hits = 0; hsum = 0;
        for (int t = 0; t <= 30; t++) begin
            step(0, 1, 0, 3'd1, 32'd3, 1, 40'(t));
            if (irq === 1'b1) begin hits++; hsum += t; end
        end
        check("periodic hit count", 40'(hits), 40'd5);
        check("periodic hit times", 40'(hsum), 40'd100);
        step(0, 0, 1, 3'd2, 32'd0, 0, 40'd31);
        check("periodic cmp", {8'b0, rdata}, 40'd35);

        // PERIOD=0: one hit per tick
        do_reset();
        step(0, 1, 0, 3'd2, 32'd40, 0, 0);
        step(0, 1, 0, 3'd3, 32'd0,  0, 0);
        step(0, 1, 0, 3'd0, 32'd7,  0, 0);
        hits = 0;
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 0, 3'd1, 32'd3, (i == 4), (i < 5) ? 40'd40 : 40'd41);
            if (irq === 1'b1) hits++;
        end
        check("period0 hit count", 40'(hits), 40'd2);

        // Catch-up: cmp lags time by several periods
        do_reset();
        step(0, 1, 0, 3'd2, 32'd10, 0, 0);
        step(0, 1, 0, 3'd3, 32'd0,  0, 0);
        step(0, 1, 0, 3'd4, 32'd5,  0, 0);
        step(0, 1, 0, 3'd0, 32'd7,  0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 3'd0, 32'd0, 0, 40'd30);
        step(0, 0, 1, 3'd2, 32'd0, 0, 40'd30);
        check("catchup cmp", {8'b0, rdata}, 40'd35);
        step(0, 0, 1, 3'd1, 32'd0, 0, 40'd30);
        check("catchup status", {8'b0, rdata}, 40'd3);
`else
        // Periodic feature absent: PERIOD and CTRL.PERIODIC read 0, hits are one-shot
        do_reset();
        step(0, 1, 0, 3'd4, 32'd5, 0, 0);
        step(0, 1, 0, 3'd0, 32'd7, 0, 0);
        step(0, 0, 1, 3'd4, 32'd0, 0, 0);
        check("noper period", {8'b0, rdata}, 40'd0);
        step(0, 0, 1, 3'd0, 32'd0, 0, 0);
        check("noper ctrl", {8'b0, rdata}, 40'd3);
        step(0, 1, 0, 3'd2, 32'd20, 0, 0);
        step(0, 1, 0, 3'd3, 32'd0,  0, 0);
        step(0, 0, 0, 3'd0, 32'd0,  0, 40'd20);
        check("noper hit irq_o", {39'b0, irq}, 40'd1);
        step(0, 0, 1, 3'd0, 32'd0,  0, 40'd21);
        check("noper disarm ctrl", {8'b0, rdata}, 40'd2);
`endif

        // Random traffic against the model
        do_reset();
        tr = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          r, w, rdd, tk;
            logic [2:0]  a;
            logic [31:0] d;
            r   = ($urandom_range(0, 499) == 0);
            w   = ($urandom_range(0, 3) == 0);
            rdd = ($urandom_range(0, 2) == 0);
            tk  = 1'($urandom_range(0, 1));
            a   = 3'($urandom_range(0, 7));
            case (a)
                3'd0:    d = 32'($urandom_range(0, 7));
                3'd1:    d = 32'($urandom_range(0, 3));
                3'd2:    d = tr[31:0] + 32'($urandom_range(0, 30));
                3'd3:    d = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 255))
                                                          : {24'b0, tr[39:32]};
                3'd4:    d = 32'($urandom_range(0, 6));
                default: d = $urandom;
            endcase
            step(r, w, rdd, a, d, tk, tr);
            if (tk) tr = tr + 40'd1;
            if ($urandom_range(0, 199) == 0) tr = tr + 40'd40;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
